// File: rtl/muldiv_seq_if.sv
// Handshake and ALU-sharing bundle between the EX stage and the MULTU/DIVU
// sequencer. The sequencer (slave) borrows the shared ALU through alu_*.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_div;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;

  modport master (
    output start, is_div, rs, rt, alu_y,
    input  busy, done, hi, lo, alu_op, alu_a, alu_b
  );

  modport slave (
    input  start, is_div, rs, rt, alu_y,
    output busy, done, hi, lo, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/muldiv_seq.sv
// MULTU/DIVU sequencer: one shift-add (multiply) or restoring-subtract
// (divide) iteration per cycle through the shared ALU, result in HI/LO.
//
// state | meaning
// IDLE  | waiting for start; ALU not used
// RUN   | one iteration per cycle, WIDTH iterations
// DONE  | hi/lo valid, done pulses for one cycle
module muldiv_seq #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor, depending on is_div_q
  logic             is_div_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] sh;
  logic             carry;
  logic             accept;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;

  // Drive the shared ALU and compute the next working-register values
  always_comb begin
    alu_op = 4'b0000;
    alu_a  = '0;
    alu_b  = '0;
    sh     = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
    carry  = 1'b0;
    accept = 1'b0;
    acc_d  = acc_q;
    mq_d   = mq_q;
    if (state_q == S_RUN) begin
      if (is_div_q) begin
        alu_op = OP_SUB;
        alu_a  = sh;
        alu_b  = opnd_q;
        // A set msb means the shifted remainder exceeds WIDTH bits, so it
        // is always >= divisor; the ALU's wrapped difference is still right.
        accept = acc_q[WIDTH-1] | (sh >= opnd_q);
        acc_d  = accept ? bus.alu_y : sh;
        mq_d   = {mq_q[WIDTH-2:0], accept};
      end else begin
        alu_op = OP_ADD;
        alu_a  = acc_q;
        alu_b  = mq_q[0] ? opnd_q : '0;
        carry  = (bus.alu_y < alu_a);
        acc_d  = {carry, bus.alu_y[WIDTH-1:1]};
        mq_d   = {bus.alu_y[0], mq_q[WIDTH-1:1]};
      end
    end
  end

  // Sequencer FSM with registered busy/done and HI/LO result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mq_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.is_div && (bus.rt == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hi_q    <= bus.rs;
              lo_q    <= DIV0_LO;
            end else begin
              state_q  <= S_RUN;
              is_div_q <= bus.is_div;
              acc_q    <= '0;
              count_q  <= '0;
              mq_q     <= bus.is_div ? bus.rs : bus.rt;
              opnd_q   <= bus.is_div ? bus.rt : bus.rs;
            end
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          mq_q    <= mq_d;
          count_q <= count_q + 1'b1;
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            hi_q    <= acc_d;
            lo_q    <= mq_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.alu_op = alu_op;
  assign bus.alu_a  = alu_a;
  assign bus.alu_b  = alu_b;
endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W), .DIV0_LO(32'hFFFFFFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU model: add / sub, zero otherwise
  always_comb begin
    case (bus.alu_op)
      4'b0010: bus.alu_y = bus.alu_a + bus.alu_b;
      4'b0110: bus.alu_y = bus.alu_a - bus.alu_b;
      default: bus.alu_y = '0;
    endcase
  end

  // Issue one operation now (accepted at the next posedge = edge 0), then
  // watch cycles 1..40 at negedge until done, plus one more cycle.
  task automatic do_op(input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int done_cyc, output int busy_cyc, output int run_cyc,
                       output int op_bad, output logic [W-1:0] hi_v,
                       output logic [W-1:0] lo_v, output logic after_ok);
    logic [3:0] exp_op;
    exp_op   = div ? 4'b0110 : 4'b0010;
    done_cyc = -1;
    busy_cyc = 0;
    run_cyc  = 0;
    op_bad   = 0;
    hi_v     = '0;
    lo_v     = '0;
    bus.start = 1'b1; bus.is_div = div; bus.rs = a; bus.rt = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.busy && !bus.done) begin
        run_cyc++;
        if (bus.alu_op !== exp_op) op_bad++;
      end
      if (!bus.busy && bus.alu_op !== 4'b0000) op_bad++;
      if (bus.done) begin
        done_cyc = c;
        hi_v = bus.hi;
        lo_v = bus.lo;
        break;
      end
    end
    @(negedge clk);
    after_ok = (bus.done === 1'b0) && (bus.busy === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.is_div = 1'b0; bus.rs = 32'd9; bus.rt = 32'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
    total++; if (bus.alu_op !== 4'b0000) begin bad++; $display("FAIL reset_aluop got=%b want=0000", bus.alu_op); end
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int dc, bc, rc, ob; logic [W-1:0] h, l; logic ok;
    do_op(1'b0, 32'd7, 32'd6, dc, bc, rc, ob, h, l, ok);
    total++; if (dc !== 33) begin bad++; $display("FAIL mul7x6_done_cycle got=%0d want=33", dc); end
    total++; if (bc !== 33) begin bad++; $display("FAIL mul7x6_busy_cycles got=%0d want=33", bc); end
    total++; if (ob !== 0) begin bad++; $display("FAIL mul7x6_aluop bad_cycles=%0d want=0", ob); end
    total++; if (h !== 32'h0 || l !== 32'd42) begin bad++; $display("FAIL mul7x6 got=%h_%h want=00000000_0000002a", h, l); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mul7x6_done_len got=%b want=1", ok); end
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, bc, rc, ob, h, l, ok);
    total++; if (h !== 32'hFFFFFFFE || l !== 32'h00000001) begin bad++; $display("FAIL mul_max got=%h_%h want=fffffffe_00000001", h, l); end
    total++; if (dc !== 33) begin bad++; $display("FAIL mul_max_done_cycle got=%0d want=33", dc); end
  endtask

  task automatic test_div();
    int dc, bc, rc, ob; logic [W-1:0] h, l; logic ok;
    do_op(1'b1, 32'd100, 32'd7, dc, bc, rc, ob, h, l, ok);
    total++; if (h !== 32'd2 || l !== 32'd14) begin bad++; $display("FAIL div100_7 got=hi %h lo %h want=hi 2 lo e", h, l); end
    total++; if (ob !== 0) begin bad++; $display("FAIL div100_7_aluop bad_cycles=%0d want=0", ob); end
    total++; if (dc !== 33) begin bad++; $display("FAIL div100_7_done_cycle got=%0d want=33", dc); end
    do_op(1'b1, 32'hFFFFFFFF, 32'd2, dc, bc, rc, ob, h, l, ok);
    total++; if (h !== 32'd1 || l !== 32'h7FFFFFFF) begin bad++; $display("FAIL divmax_2 got=hi %h lo %h want=hi 1 lo 7fffffff", h, l); end
    do_op(1'b1, 32'h80000000, 32'h80000001, dc, bc, rc, ob, h, l, ok);
    total++; if (h !== 32'h80000000 || l !== 32'h0) begin bad++; $display("FAIL div_msb got=hi %h lo %h want=hi 80000000 lo 0", h, l); end
  endtask

  task automatic test_div0();
    int dc, bc, rc, ob; logic [W-1:0] h, l; logic ok;
    do_op(1'b1, 32'd1234, 32'd0, dc, bc, rc, ob, h, l, ok);
    total++; if (dc !== 1) begin bad++; $display("FAIL div0_done_cycle got=%0d want=1", dc); end
    total++; if (rc !== 0) begin bad++; $display("FAIL div0_run_cycles got=%0d want=0", rc); end
    total++; if (h !== 32'd1234 || l !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0 got=hi %h lo %h want=hi 4d2 lo ffffffff", h, l); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL div0_after got=%b want=1", ok); end
  endtask

  task automatic test_back_to_back();
    int dc, bc, rc, ob; logic [W-1:0] h, l; logic ok;
    int first_done;
    logic [W-1:0] hi_run, lo_run;
    first_done = -1;
    hi_run = bus.hi; lo_run = bus.lo;
    bus.start = 1'b1; bus.is_div = 1'b1; bus.rs = 32'd100; bus.rt = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 20) begin
        total++;
        if (bus.hi !== hi_run || bus.lo !== lo_run) begin
          bad++; $display("FAIL hilo_hold_in_run got=%h_%h want=%h_%h", bus.hi, bus.lo, hi_run, lo_run);
        end
      end
      if (bus.done) begin
        first_done = c;
        break;
      end
      if (c == 10) begin
        bus.start = 1'b1; bus.is_div = 1'b0; bus.rs = 32'd3; bus.rt = 32'd3;
      end
      if (c == 11) bus.start = 1'b0;
    end
    total++; if (first_done !== 33) begin bad++; $display("FAIL ignore_done_cycle got=%0d want=33", first_done); end
    total++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin bad++; $display("FAIL ignore_result got=hi %h lo %h want=hi 2 lo e", bus.hi, bus.lo); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_after got=done %b busy %b want=0 0", bus.done, bus.busy); end
    do_op(1'b0, 32'd3, 32'd3, dc, bc, rc, ob, h, l, ok);
    total++; if (dc !== 33) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=33", dc); end
    total++; if (h !== 32'd0 || l !== 32'd9) begin bad++; $display("FAIL b2b_result got=%h_%h want=00000000_00000009", h, l); end
  endtask

  task automatic test_reset_abort();
    int dc, bc, rc, ob; logic [W-1:0] h, l; logic ok;
    int done_seen;
    int busy_seen;
    done_seen = 0;
    busy_seen = 0;
    bus.start = 1'b1; bus.is_div = 1'b0; bus.rs = 32'd5; bus.rt = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 16; c <= 45; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
      if (bus.busy) busy_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL abort_done_pulses got=%0d want=0", done_seen); end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL abort_busy_cycles got=%0d want=0", busy_seen); end
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin bad++; $display("FAIL abort_hilo got=%h_%h want=0_0", bus.hi, bus.lo); end
    do_op(1'b0, 32'd2, 32'd3, dc, bc, rc, ob, h, l, ok);
    total++; if (h !== 32'd0 || l !== 32'd6) begin bad++; $display("FAIL after_abort_mul got=%h_%h want=00000000_00000006", h, l); end
    total++; if (dc !== 33) begin bad++; $display("FAIL after_abort_done_cycle got=%0d want=33", dc); end
  endtask

  initial begin
    bus.start = 1'b0; bus.is_div = 1'b0; bus.rs = '0; bus.rt = '0;
    test_reset();
    test_mul();
    test_div();
    test_div0();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle sequencer for MIPS MULTU/DIVU. It reuses the shared 32-bit ALU (add/sub) one iteration per cycle and builds the 64-bit result into the HI/LO registers. It sits beside the EX stage; the pipeline stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; must equal the ALU width; the iteration count equals WIDTH.
DIV0_LO, 32'hFFFFFFFF, LO value returned on divide-by-zero.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
start  in  1  request a new operation; sampled only in IDLE
is_div  in  1  1 = DIVU, 0 = MULTU; sampled with start
rs  in  WIDTH  multiplicand / dividend
rt  in  WIDTH  multiplier / divisor
busy  out  1  high while in RUN or DONE
done  out  1  one-cycle pulse when hi/lo are valid
hi  out  WIDTH  product[63:32] / remainder
lo  out  WIDTH  product[31:0] / quotient
alu_op  out  4  ALU opcode: 0010 = add, 0110 = sub
alu_a  out  WIDTH  ALU operand a
alu_b  out  WIDTH  ALU operand b
alu_y  in  WIDTH  ALU result (combinational, same cycle)

Behaviour:
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, hi = 0, lo = 0.
  - Internal acc, mq, divisor and count registers = 0.
- While rst is high, all inputs are ignored. Reset mid-operation aborts and clears everything; no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - alu_op = 0000, alu_a = 0, alu_b = 0.
  - start = 1, rt != 0 or is_div = 0: latch operands, count = 0, go to RUN. For MUL: acc = 0, mq = rt, mcand = rs. For DIV: acc = 0, mq = rs, divisor = rt.
  - start = 1, is_div = 1, rt = 0: go to DONE directly. hi = rs, lo = DIV0_LO.
- RUN, MUL step (per cycle):
  - alu_op = 0010, alu_a = acc, alu_b = mq[0] ? mcand : 0.
  - carry = (alu_y < alu_a), unsigned.
  - {acc, mq} <= {carry, alu_y, mq[WIDTH-1:1]}.
- RUN, DIV step (restoring, per cycle):
  - sh = {acc[WIDTH-2:0], mq[WIDTH-1]}, msb = acc[WIDTH-1].
  - alu_op = 0110, alu_a = sh, alu_b = divisor.
  - accept = msb | (sh >= divisor).
  - acc <= accept ? alu_y : sh.
  - mq <= {mq[WIDTH-2:0], accept}.
- RUN exit: count increments each cycle. After WIDTH steps (count = WIDTH-1 completing), go to DONE and write hi <= acc, lo <= mq (the post-step values).
- DONE: done = 1 for exactly one cycle, then go to IDLE. busy = 1 in DONE.
- Latency: start accepted at edge 0; done is high in cycle WIDTH+1 (33), and hi/lo are valid in that cycle. Divide-by-zero: done in cycle 1.
- Holding and ignoring:
  - start while busy is ignored; no queueing.
  - hi/lo hold their value until the next done. They are not disturbed during RUN (separate working registers acc/mq).
  - start may be re-asserted in the cycle after DONE (back-to-back operations). Minimum interval is 34 cycles.
- Arithmetic is unsigned only, with no overflow flag. The ALU zero output is not used.

Test Plan:
- MULTU rs=7, rt=6 -> busy=1 for 33 cycles; done pulses in cycle 33; hi=0, lo=42; alu_op=0010 every RUN cycle.
- MULTU rs=rt=FFFFFFFF -> hi=FFFFFFFE, lo=00000001 (exercises the carry path).
- DIVU rs=100, rt=7 -> lo=14, hi=2. DIVU rs=FFFFFFFF, rt=2 -> lo=7FFFFFFF, hi=1. DIVU rs=80000000, rt=80000001 -> lo=0, hi=80000000.
- DIVU rs=1234, rt=0 -> done in cycle 1; hi=1234, lo=FFFFFFFF; no RUN cycles.
- Start divide 100/7. Pulse start with 3*3 at cycle 10 -> ignored; result is still lo=14, hi=2. Then a back-to-back MULTU 3*3 started the cycle after done -> lo=9.
- Start MULTU 5*5. Assert rst at cycle 15 for 1 cycle -> busy=0, done never pulses, hi=lo=0. Next op 2*3 -> lo=6.
